// File: rtl/rv32i_pad_pkg.sv
// Shared types and defaults for the user-pad arbiter and its round-robin picker.
package rv32i_pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int unsigned DW_DEF   = 16;
  localparam int unsigned NREQ_DEF = 2;
  localparam int unsigned HOLD_DEF = 4;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/rv32i_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr_i, wrapping.
module rv32i_rr_pick
  import rv32i_pad_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   gnt_o,
  output logic            valid_o
);

  int unsigned k;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr_i) + i) % NREQ;
      if (!valid_o && req_i[IW'(k)]) begin
        gnt_o   = IW'(k);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32i_pad_arbiter.sv
// Round-robin owner of the shared user pads; each grant drives one word for HOLD cycles.
// Optional bus-turnaround cycle between words: define RV32I_PAD_GAP_EN.
module rv32i_pad_arbiter
  import rv32i_pad_pkg::*;
#(
  parameter  int unsigned DW   = DW_DEF,
  parameter  int unsigned NREQ = NREQ_DEF,
  parameter  int unsigned HOLD = HOLD_DEF,
  localparam int unsigned OW   = idx_w(NREQ),
  localparam int unsigned CW   = idx_w(HOLD)
) (
  input  logic              clk,
  input  logic              RN,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*DW-1:0] data_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [DW-1:0]     pad_out,
  output logic [DW-1:0]     pad_oeb,
  output logic              busy_o,
  output logic [OW-1:0]     owner_o
);

  state_e          state_q, state_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   out_q, out_d;
  logic [DW-1:0]   oeb_q, oeb_d;
  logic            busy_q, busy_d;
  logic [OW-1:0]   owner_q, owner_d;

  logic            arb_c;
  logic [OW-1:0]   gnt_c;
  logic            gnt_vld_c;
  logic [DW-1:0]   gnt_data_c;
  logic [NREQ-1:0] gnt_onehot_c;

  rv32i_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (req_i),
    .ptr_i   (rr_q),
    .gnt_o   (gnt_c),
    .valid_o (gnt_vld_c)
  );

  // Decode the winning index into its data slice and ack bit.
  always_comb begin
    gnt_data_c   = '0;
    gnt_onehot_c = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (gnt_c == OW'(j)) begin
        gnt_data_c      = data_i[j*DW +: DW];
        gnt_onehot_c[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    out_d   = out_q;
    oeb_d   = oeb_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    arb_c   = 1'b0;

    case (state_q)
      ST_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
`ifdef RV32I_PAD_GAP_EN
          state_d = ST_GAP;
          oeb_d   = '1;
          busy_d  = 1'b0;
`else
          arb_c = 1'b1;
`endif
        end
      end
      default: arb_c = 1'b1;
    endcase

    if (arb_c) begin
      if (gnt_vld_c) begin
        state_d = ST_DRIVE;
        out_d   = gnt_data_c;
        oeb_d   = '0;
        ack_d   = gnt_onehot_c;
        owner_d = gnt_c;
        cnt_d   = CW'(HOLD - 1);
        rr_d    = OW'((32'(gnt_c) + 32'd1) % NREQ);
        busy_d  = 1'b1;
      end else begin
        // Nothing to drive: float the pads but keep the last data word.
        state_d = ST_IDLE;
        oeb_d   = '1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      out_q   <= '0;
      oeb_q   <= '1;
      busy_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  assign ack_o   = ack_q;
  assign pad_out = out_q;
  assign pad_oeb = oeb_q;
  assign busy_o  = busy_q;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_rv32i_pad_arbiter.sv
// Directed vector bench for rv32i_pad_arbiter (default build, NREQ=2, HOLD=4 and HOLD=1).
module tb_rv32i_pad_arbiter;

  logic        clk;
  logic        rn;
  logic [1:0]  req;
  logic [31:0] data;
  logic [1:0]  ack;
  logic [15:0] pout, poeb;
  logic        busy;
  logic [0:0]  owner;

  logic [1:0]  req_h1;
  logic [31:0] data_h1;
  logic [1:0]  ack_h1;
  logic [15:0] pout_h1, poeb_h1;
  logic        busy_h1;
  logic [0:0]  owner_h1;

  int checks;
  int failures;

  typedef struct packed {
    logic [1:0]  req;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  ack;
    logic [15:0] out;
    logic [15:0] oeb;
    logic        busy;
    logic        owner;
  } vec_t;

  vec_t tbl[$];

  rv32i_pad_arbiter #(.DW(16), .NREQ(2), .HOLD(4)) u_dut (
    .clk     (clk),
    .RN      (rn),
    .req_i   (req),
    .data_i  (data),
    .ack_o   (ack),
    .pad_out (pout),
    .pad_oeb (poeb),
    .busy_o  (busy),
    .owner_o (owner)
  );

  rv32i_pad_arbiter #(.DW(16), .NREQ(2), .HOLD(1)) u_h1 (
    .clk     (clk),
    .RN      (rn),
    .req_i   (req_h1),
    .data_i  (data_h1),
    .ack_o   (ack_h1),
    .pad_out (pout_h1),
    .pad_oeb (poeb_h1),
    .busy_o  (busy_h1),
    .owner_o (owner_h1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [1:0] a, input logic [15:0] o,
                          input logic [15:0] e, input logic b, input logic w);
    chk({nm, ".ack"},   32'(ack),   32'(a));
    chk({nm, ".out"},   32'(pout),  32'(o));
    chk({nm, ".oeb"},   32'(poeb),  32'(e));
    chk({nm, ".busy"},  32'(busy),  32'(b));
    chk({nm, ".owner"}, 32'(owner), 32'(w));
  endtask

  task automatic add(input logic [1:0] r, input logic [15:0] d0, input logic [15:0] d1,
                     input logic [1:0] a, input logic [15:0] o, input logic [15:0] e,
                     input logic b, input logic w);
    vec_t v;
    v.req = r; v.d0 = d0; v.d1 = d1; v.ack = a;
    v.out = o; v.oeb = e; v.busy = b; v.owner = w;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rn       = 1'b0;
    req      = '0;
    data     = '0;
    req_h1   = '0;
    data_h1  = '0;

    // Both requesters held: 1111 x4, 2222 x4, 1111 x4, then float.
    add(2'b11, 16'h1111, 16'h2222, 2'b01, 16'h1111, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(2'b11, 16'h1111, 16'h2222, 2'b00, 16'h1111, 16'h0000, 1'b1, 1'b0);
    add(2'b11, 16'h1111, 16'h2222, 2'b10, 16'h2222, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) add(2'b11, 16'h1111, 16'h2222, 2'b00, 16'h2222, 16'h0000, 1'b1, 1'b1);
    add(2'b11, 16'h1111, 16'h2222, 2'b01, 16'h1111, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(2'b00, 16'h1111, 16'h2222, 2'b00, 16'h1111, 16'h0000, 1'b1, 1'b0);
    add(2'b00, 16'h1111, 16'h2222, 2'b00, 16'h1111, 16'hFFFF, 1'b0, 1'b0);
    // Single word from requester 0 while the pointer sits at 1.
    add(2'b01, 16'hA5A5, 16'h0000, 2'b01, 16'hA5A5, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(2'b00, 16'hA5A5, 16'h0000, 2'b00, 16'hA5A5, 16'h0000, 1'b1, 1'b0);
    add(2'b00, 16'hA5A5, 16'h0000, 2'b00, 16'hA5A5, 16'hFFFF, 1'b0, 1'b0);
    // Requester 1 pulses mid-word and withdraws: never granted.
    add(2'b01, 16'hBEEF, 16'hCAFE, 2'b01, 16'hBEEF, 16'h0000, 1'b1, 1'b0);
    add(2'b10, 16'hBEEF, 16'hCAFE, 2'b00, 16'hBEEF, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) add(2'b00, 16'hBEEF, 16'hCAFE, 2'b00, 16'hBEEF, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) add(2'b00, 16'hBEEF, 16'hCAFE, 2'b00, 16'hBEEF, 16'hFFFF, 1'b0, 1'b0);

    #12;
    chk_outs("rst", 2'b00, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk);
    rn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      chk_outs($sformatf("idle%0d", i), 2'b00, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    end

    foreach (tbl[i]) begin
      req  = tbl[i].req;
      data = {tbl[i].d1, tbl[i].d0};
      step();
      chk_outs($sformatf("vec%0d", i), tbl[i].ack, tbl[i].out, tbl[i].oeb, tbl[i].busy, tbl[i].owner);
    end

    // Reset in the 2nd drive cycle after a grant to 0 leaves pointer at 1 unless reset clears it.
    req  = 2'b01;
    data = {16'h0000, 16'h1234};
    step();
    chk_outs("rstA.grant", 2'b01, 16'h1234, 16'h0000, 1'b1, 1'b0);
    req = 2'b00;
    step();
    #2 rn = 1'b0;
    #1 chk_outs("rstA.async", 2'b00, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk);
    rn   = 1'b1;
    req  = 2'b11;
    data = {16'h5678, 16'h9ABC};
    step();
    chk_outs("rstA.ptr0", 2'b01, 16'h9ABC, 16'h0000, 1'b1, 1'b0);
    req = 2'b00;
    step();
    #2 rn = 1'b0;
    #1 chk_outs("rstB.async", 2'b00, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk);
    rn  = 1'b1;
    req = 2'b10;
    step();
    chk_outs("rstB.req1", 2'b10, 16'h5678, 16'h0000, 1'b1, 1'b1);
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_outs($sformatf("rstB.hold%0d", i), 2'b00, 16'h5678, 16'h0000, 1'b1, 1'b1);
    end
    step();
    chk_outs("rstB.end", 2'b00, 16'h5678, 16'hFFFF, 1'b0, 1'b1);

    // HOLD=1: a fresh word and ack every cycle under a continuous request.
    req_h1 = 2'b01;
    for (int i = 0; i < 6; i++) begin
      data_h1 = {16'h0000, 16'(32'h1000 + 32'(i))};
      step();
      chk($sformatf("h1.ack%0d", i), 32'(ack_h1), 32'h1);
      chk($sformatf("h1.out%0d", i), 32'(pout_h1), 32'h1000 + 32'(i));
      chk($sformatf("h1.oeb%0d", i), 32'(poeb_h1), 32'h0);
      chk($sformatf("h1.busy%0d", i), 32'(busy_h1), 32'h1);
    end
    req_h1 = 2'b00;
    step();
    chk("h1.end.oeb", 32'(poeb_h1), 32'hFFFF);
    chk("h1.end.ack", 32'(ack_h1), 32'h0);
    chk("h1.end.out", 32'(pout_h1), 32'h1005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
